// File: rtl/v74x139_rr_arbiter.sv
// Round-robin arbiter sharing one 74x139 decoder half among four requesters.
// Drives the decoder select/enable, mirrors the active-low grant, and enforces hold timeout plus a one-cycle gap.
module v74x139_rr_arbiter #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] REQ,
  output logic       SEL_B,
  output logic       SEL_A,
  output logic       EN_L,
  output logic [3:0] GNT_L,
  output logic       BUSY,
  output logic       TIMEOUT,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       gidx;
  logic [CNT_W-1:0] hold_cnt;

  logic [1:0] pick;
  logic [1:0] idx_c;
  logic       req_any;
  logic       hold_hit;
  logic       release_req;

  // Scan from ptr upward; iterate farthest-first so the nearest requester is the final assignment.
  always_comb begin
    pick    = ptr;
    idx_c   = ptr;
    req_any = 1'b0;
    for (int off = 3; off >= 0; off--) begin
      idx_c = ptr + 2'(off);
      if (REQ[idx_c]) begin
        pick    = idx_c;
        req_any = 1'b1;
      end
    end
  end

  assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_req = !REQ[gidx];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      gidx     <= 2'd0;
      hold_cnt <= '0;
      EN_L     <= 1'b1;
      GNT_L    <= 4'b1111;
      BUSY     <= 1'b0;
      TIMEOUT  <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          TIMEOUT <= 1'b0;
          if (req_any) begin
            state    <= GRANT;
            gidx     <= pick;
            EN_L     <= 1'b0;
            GNT_L    <= ~(4'b0001 << pick);
            BUSY     <= 1'b1;
            hold_cnt <= '0;
          end else begin
            state <= IDLE;
            EN_L  <= 1'b1;
            GNT_L <= 4'b1111;
            BUSY  <= 1'b0;
          end
        end
        GRANT: begin
          if (release_req || hold_hit) begin
            // A voluntary release on the expiry edge is not reported as a timeout.
            state   <= GAP;
            ptr     <= gidx + 2'd1;
            EN_L    <= 1'b1;
            GNT_L   <= 4'b1111;
            BUSY    <= 1'b0;
            TIMEOUT <= !release_req;
          end else if (hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          EN_L    <= 1'b1;
          GNT_L   <= 4'b1111;
          BUSY    <= 1'b0;
          TIMEOUT <= 1'b0;
        end
      endcase
    end
  end

  // Select lines keep the last granted index while EN_L is high.
  assign SEL_B     = gidx[1];
  assign SEL_A     = gidx[0];
  assign state_dbg = state;

endmodule
